// File: rtl/pal_cfg_pkg.sv
// ============================================================================
// pal_cfg_pkg: shared state encoding and CRC constants for the PAL config streamer.
// Rev 1.0
// ============================================================================
`default_nettype none

package pal_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_SETTLE   = 3'd4,
    ST_ACTIVE   = 3'd5
  } state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  function automatic int num_words(input int len, input int w);
    return (len + w - 1) / w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pal_cfg_crc8.sv
// ============================================================================
// pal_cfg_crc8: bit-serial CRC-8 (MSB feedback), cleared at configuration start.
// Rev 1.0
// ============================================================================
`default_nettype none

module pal_cfg_crc8
  import pal_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       bit_valid_i,
  input  logic       bit_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    crc_d = crc_q;
    fb    = crc_q[7] ^ bit_i;
    if (clear_i) begin
      crc_d = '0;
    end else if (bit_valid_i) begin
      crc_d = {crc_q[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

`default_nettype wire

// File: rtl/pal_cfg_streamer.sv
// ============================================================================
// pal_cfg_streamer: serialises stream words LSB-first onto cfg_data/cfg_clk, then
// raises pal_enable. Macro PAL_CFG_CRC_EN adds a trailing CRC-8 check word. Rev 1.0
// ============================================================================
`default_nettype none

module pal_cfg_streamer
  import pal_cfg_pkg::*;
#(
  parameter int BITSTREAM_LEN = 242,
  parameter int WORD_W        = 8,
  parameter int CLK_DIV       = 2,
  parameter int SETTLE_CYC    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              cfg_data,
  output logic              cfg_clk,
  output logic              pal_enable,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W   = $clog2(BITSTREAM_LEN + 1);
  localparam int IDX_W   = $clog2(WORD_W);
  localparam int TMR_MAX = (CLK_DIV > SETTLE_CYC) ? CLK_DIV : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(BITSTREAM_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WORD_W - 1);
  localparam logic [TMR_W-1:0] DIV_END    = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] SETTLE_END = TMR_W'(SETTLE_CYC - 1);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]    bidx_q, bidx_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                cfg_data_q, cfg_data_d;
  logic                cfg_clk_q, cfg_clk_d;
  logic                pal_en_q, pal_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                chk_q, chk_d;
  logic [7:0]          crc_w;
  logic                start_ok;
  logic                bit_clocked;

  assign start_ok    = start && ((state_q == ST_IDLE) || (state_q == ST_ACTIVE));
  assign bit_clocked = (state_q == ST_SHIFT_HI) && (tmr_q == DIV_END);

`ifdef PAL_CFG_CRC_EN
  localparam bit CRC_EN = 1'b1;

  pal_cfg_crc8 u_crc (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (start_ok),
    .bit_valid_i (bit_clocked),
    .bit_i       (cfg_data_q),
    .crc_o       (crc_w)
  );
`else
  localparam bit CRC_EN = 1'b0;

  assign crc_w = 8'h00;
`endif

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    bit_cnt_d  = bit_cnt_q;
    bidx_d     = bidx_q;
    tmr_d      = '0;
    cfg_data_d = cfg_data_q;
    cfg_clk_d  = 1'b0;
    pal_en_d   = pal_en_q;
    done_d     = 1'b0;
    err_d      = err_q;
    chk_d      = chk_q;

    case (state_q)
      ST_IDLE, ST_ACTIVE: begin
        if (start_ok) begin
          state_d   = ST_LOAD;
          pal_en_d  = 1'b0;
          bit_cnt_d = '0;
          bidx_d    = '0;
          err_d     = 1'b0;
          chk_d     = 1'b0;
        end
      end
      ST_LOAD: begin
        if (s_valid) begin
          if (chk_q) begin
            chk_d = 1'b0;
            if (s_data[7:0] == crc_w) begin
              state_d = ST_SETTLE;
            end else begin
              state_d = ST_IDLE;
              err_d   = 1'b1;
            end
          end else begin
            word_d     = s_data;
            cfg_data_d = s_data[0];
            state_d    = ST_SHIFT_LO;
          end
        end
      end
      ST_SHIFT_LO: begin
        if (tmr_q == DIV_END) begin
          state_d   = ST_SHIFT_HI;
          cfg_clk_d = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_SHIFT_HI: begin
        cfg_clk_d = 1'b1;
        if (bit_clocked) begin
          cfg_clk_d = 1'b0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          // Rotate so the next bit sits at index 1 and every latched bit stays live.
          word_d    = {word_q[0], word_q[WORD_W-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            if (CRC_EN) begin
              state_d = ST_LOAD;
              chk_d   = 1'b1;
            end else begin
              state_d = ST_SETTLE;
            end
          end else if (bidx_q == LAST_IDX) begin
            state_d = ST_LOAD;
            bidx_d  = '0;
          end else begin
            state_d    = ST_SHIFT_LO;
            bidx_d     = bidx_q + 1'b1;
            cfg_data_d = word_q[1];
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (tmr_q == SETTLE_END) begin
          state_d  = ST_ACTIVE;
          pal_en_d = 1'b1;
          done_d   = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE) && (state_d != ST_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      bit_cnt_q  <= '0;
      bidx_q     <= '0;
      tmr_q      <= '0;
      cfg_data_q <= 1'b0;
      cfg_clk_q  <= 1'b0;
      pal_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      chk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      bit_cnt_q  <= bit_cnt_d;
      bidx_q     <= bidx_d;
      tmr_q      <= tmr_d;
      cfg_data_q <= cfg_data_d;
      cfg_clk_q  <= cfg_clk_d;
      pal_en_q   <= pal_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      chk_q      <= chk_d;
    end
  end

  assign s_ready    = (state_q == ST_LOAD);
  assign cfg_data   = cfg_data_q;
  assign cfg_clk    = cfg_clk_q;
  assign pal_enable = pal_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pal_cfg_streamer.sv
// ============================================================================
// tb_pal_cfg_streamer: random-stream bench with a bit-level reference of the config chain.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pal_cfg_streamer;

  localparam int LEN    = 242;
  localparam int W      = 8;
  localparam int DIV    = 2;
  localparam int SETTLE = 8;
  localparam int NW     = (LEN + W - 1) / W;
`ifdef PAL_CFG_CRC_EN
  localparam int CHK_LOADS = 1;
`else
  localparam int CHK_LOADS = 0;
`endif
  localparam int LAT = NW + CHK_LOADS + LEN * 2 * DIV + SETTLE + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         s_valid = 1'b0;
  logic [W-1:0] s_data = '0;
  logic         s_ready, cfg_data, cfg_clk, pal_enable, busy, done, err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] words[$];
  bit           exp_bits[$];
  bit           got_bits[$];
  int           done_cnt = 0;
  int           clk_viol = 0;
  int           en_rise_cyc = -1;
  logic         prev_clk = 1'b0;
  logic         prev_en  = 1'b0;

  pal_cfg_streamer #(
    .BITSTREAM_LEN (LEN),
    .WORD_W        (W),
    .CLK_DIV       (DIV),
    .SETTLE_CYC    (SETTLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .cfg_data   (cfg_data),
    .cfg_clk    (cfg_clk),
    .pal_enable (pal_enable),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Chain observer: records the data bit seen at every rising cfg_clk.
  always @(negedge clk) begin
    if (cfg_clk === 1'b1 && prev_clk === 1'b0) got_bits.push_back(cfg_data);
    if (s_ready === 1'b1 && cfg_clk === 1'b1) clk_viol <= clk_viol + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (pal_enable === 1'b1 && prev_en === 1'b0) en_rise_cyc <= cyc;
    prev_clk <= cfg_clk;
    prev_en  <= pal_enable;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_crc();
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    foreach (exp_bits[i]) begin
      fb = c[7] ^ exp_bits[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic make_words(input bit trunc, input bit crc_bad);
    logic [W-1:0] w;
    words.delete();
    exp_bits.delete();
    for (int k = 0; k < NW; k++) begin
      w = W'($urandom);
      if (trunc && k == NW - 1) w = 8'hFC;
      words.push_back(w);
    end
    for (int i = 0; i < LEN; i++) begin
      w = words[i / W];
      exp_bits.push_back(w[i % W]);
    end
`ifdef PAL_CFG_CRC_EN
    w = '0;
    w[7:0] = ref_crc();
    if (crc_bad) w[0] = ~w[0];
    words.push_back(w);
`else
    if (crc_bad) $display("note: check word not used in this build");
`endif
  endtask

  task automatic pulse_start(output int s_cyc);
    @(negedge clk);
    start = 1'b1;
    s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int throttle, input int stop_bits, input int base, input bit stray);
    int idx = 0;
    int gap;
    int guard = 0;
    bit hs;
    bit stray_done = 1'b0;
    gap = throttle;
    while (idx < words.size() && guard < 20000) begin
      if (gap > 0) begin
        s_valid = 1'b0;
        gap--;
      end else begin
        s_valid = 1'b1;
        s_data  = words[idx];
      end
      start = stray && idx == 5 && !stray_done;
      if (start) stray_done = 1'b1;
      hs = s_valid && s_ready;
      @(negedge clk);
      guard++;
      if (hs) begin
        idx++;
        gap = throttle;
      end
      if (stop_bits > 0 && got_bits.size() - base >= stop_bits) break;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    if (guard >= 20000) check("feed_timeout", guard, 0);
  endtask

  task automatic wait_idle(output bit ok, output int ones);
    ok   = 1'b0;
    ones = 0;
    for (int n = 0; n < 5000; n++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      if (cfg_data === 1'b1) ones++;
      @(negedge clk);
    end
  endtask

  task automatic full_run(input string tag, input int throttle, input bit trunc,
                          input bit stray, input bit crc_bad);
    int s_cyc, base, d0, v0, ones, nbad;
    bit ok;
    make_words(trunc, crc_bad);
    base = got_bits.size();
    d0   = done_cnt;
    v0   = clk_viol;
    pulse_start(s_cyc);
    check({tag, "_en_cleared"}, pal_enable, 0);
    check({tag, "_busy"}, busy, 1);
    feed(throttle, 0, base, stray);
    wait_idle(ok, ones);
    check({tag, "_finished"}, ok, 1);
    repeat (2) @(negedge clk);
    check({tag, "_rises"}, got_bits.size() - base, LEN);
    nbad = 0;
    for (int i = 0; i < LEN; i++) begin
      if (base + i >= got_bits.size() || got_bits[base + i] != exp_bits[i]) nbad++;
    end
    check({tag, "_bit_errors"}, nbad, 0);
    check({tag, "_clk_in_stall"}, clk_viol - v0, 0);
    if (trunc) check({tag, "_tail_leak"}, ones, 0);
    check({tag, "_busy_end"}, busy, 0);
    if (!crc_bad) begin
      check({tag, "_pal_en"}, pal_enable, 1);
      check({tag, "_done_pulses"}, done_cnt - d0, 1);
      check({tag, "_err"}, err, 0);
      if (throttle == 0) check({tag, "_en_latency"}, en_rise_cyc - s_cyc, LAT);
    end else begin
      check({tag, "_pal_en"}, pal_enable, 0);
      check({tag, "_done_pulses"}, done_cnt - d0, 0);
      check({tag, "_err"}, err, 1);
      check({tag, "_ready_idle"}, s_ready, 0);
    end
  endtask

  initial begin
    int s_cyc, base;
    repeat (3) @(negedge clk);
    check("rst_cfg_data", cfg_data, 0);
    check("rst_cfg_clk", cfg_clk, 0);
    check("rst_pal_en", pal_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ready", s_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", s_ready, 0);

    full_run("plain", 0, 1'b0, 1'b0, 1'b0);
    full_run("throttle", 5, 1'b0, 1'b0, 1'b0);
    full_run("trunc", 0, 1'b1, 1'b0, 1'b0);

    make_words(1'b0, 1'b0);
    base = got_bits.size();
    pulse_start(s_cyc);
    feed(0, 100, base, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outputs", {s_ready, cfg_data, cfg_clk, pal_enable, busy, done, err}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_stays_idle", {busy, s_ready}, 0);

    full_run("after_rst", 0, 1'b0, 1'b0, 1'b0);
    full_run("reconfig", 0, 1'b0, 1'b1, 1'b0);
`ifdef PAL_CFG_CRC_EN
    full_run("crc_bad", 0, 1'b0, 1'b0, 1'b1);
    full_run("crc_recover", 0, 1'b0, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
